// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Consumer end of the ALU result interface. Every cycle with arith_flag_in
//   high captures {carry_in, arith_out_in} into a DEPTH-entry FIFO. The head
//   entry is streamed downstream as two OUT_W words over valid/ready: the low
//   half first (out_last=0), then the high half (out_last=1). The entry is
//   popped on the high-half handshake. Throughput is one result per two
//   cycles, so back-to-back strobes fill the FIFO; a strobe that finds it
//   full, with no pop in the same cycle, is dropped and sets sticky overflow.
//
// Parameters
//   RES_W  incoming result width (must equal 2*OUT_W)
//   OUT_W  downstream word width
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   arith_flag_in   result strobe, one result per high cycle
//   arith_out_in    result word
//   carry_in        carry accompanying the result
//   clear           synchronous flush of FIFO, beat state and overflow
//   out_data/out_valid/out_ready/out_last/out_carry  downstream stream
//   fifo_count      entries held, including the one in flight
//   overflow        sticky drop indicator
//   drop_count      (COLLECTOR_DROP_COUNT_EN only) saturating 8-bit drop count
//
// Build option
//   COLLECTOR_DROP_COUNT_EN  adds the drop_count port and counter.
module alu_result_collector #(
  parameter int RES_W = 32,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arith_flag_in,
  input  logic [RES_W-1:0]           arith_out_in,
  input  logic                       carry_in,
  input  logic                       clear,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       out_carry,
  output logic [$clog2(DEPTH):0]     fifo_count,
`ifdef COLLECTOR_DROP_COUNT_EN
  output logic [7:0]                 drop_count,
`endif
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {BEAT_LO = 1'b0, BEAT_HI = 1'b1} beat_t;

  // Entry layout: {carry, result}
  logic [RES_W:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  beat_t           beat_q, beat_d;
  logic            overflow_q, overflow_d;

  logic            valid, full, hs, pop, push, drop;
  logic [RES_W:0]  head;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign hs    = valid & out_ready;
  assign pop   = hs & (beat_q == BEAT_HI);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the head is leaving.
  assign push  = arith_flag_in & (~full | pop);
  assign drop  = arith_flag_in & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_d     = beat_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);   // power-of-two DEPTH wraps naturally
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (hs) beat_d = (beat_q == BEAT_LO) ? BEAT_HI : BEAT_LO;
    // clear overrides push, pop and drop
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      beat_d     = BEAT_LO;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= BEAT_LO;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: every output derived from it is gated by valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= {carry_in, arith_out_in};
  end

  assign head = mem_q[rd_ptr_q];

  // Outputs decode from registered state only, so they cannot change while
  // out_valid is held under backpressure.
  assign out_valid  = valid;
  assign out_last   = valid & (beat_q == BEAT_HI);
  assign out_carry  = valid & head[RES_W];
  assign out_data   = !valid            ? '0 :
                      (beat_q == BEAT_HI) ? head[RES_W-1:OUT_W] : head[OUT_W-1:0];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

`ifdef COLLECTOR_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            drop_cnt_q <= '0;
    else if (clear)                     drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        arith_flag_in;
  logic [31:0] arith_out_in;
  logic        carry_in;
  logic        clear;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_carry;
  logic [2:0]  fifo_count;
  logic        overflow;
`ifdef COLLECTOR_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int errors = 0;
  int checks = 0;

  alu_result_collector #(.RES_W(32), .OUT_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .arith_flag_in(arith_flag_in), .arith_out_in(arith_out_in), .carry_in(carry_in),
    .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_carry(out_carry),
    .fifo_count(fifo_count),
`ifdef COLLECTOR_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic c);
    arith_flag_in = 1'b1;
    arith_out_in  = d;
    carry_in      = c;
    step();
    arith_flag_in = 1'b0;
  endtask

  // Expect both beats of one result, accepting each with ready high.
  task automatic drain_one(input string tag, input logic [31:0] d, input logic c);
    out_ready = 1'b1;
    chk({tag, "_lo"},   {16'h0, out_data}, {16'h0, d[15:0]});
    chk({tag, "_lo_l"}, {31'h0, out_last}, 32'd0);
    chk({tag, "_lo_c"}, {31'h0, out_carry}, {31'h0, c});
    step();
    chk({tag, "_hi"},   {16'h0, out_data}, {16'h0, d[31:16]});
    chk({tag, "_hi_l"}, {31'h0, out_last}, 32'd1);
    chk({tag, "_hi_c"}, {31'h0, out_carry}, {31'h0, c});
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'd0);
    chk({tag, "_last"},  {31'h0, out_last},  32'd0);
    chk({tag, "_data"},  {16'h0, out_data},  32'd0);
    chk({tag, "_carry"}, {31'h0, out_carry}, 32'd0);
    chk({tag, "_count"}, {29'h0, fifo_count}, 32'd0);
    chk({tag, "_ovf"},   {31'h0, overflow},  32'd0);
  endtask

  initial begin
    rst = 1'b1; arith_flag_in = 1'b0; arith_out_in = '0; carry_in = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    #12;
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Single result, ready held high
    out_ready = 1'b1;
    push(32'h1234_ABCD, 1'b1);
    chk("single_valid", {31'h0, out_valid}, 32'd1);
    chk("single_count", {29'h0, fifo_count}, 32'd1);
    drain_one("single", 32'h1234_ABCD, 1'b1);
    chk("single_empty", {29'h0, fifo_count}, 32'd0);
    chk("single_novalid", {31'h0, out_valid}, 32'd0);

    // Backpressure: word must hold stable while ready is low
    out_ready = 1'b0;
    push(32'hFFFF_8000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data",  {16'h0, out_data}, 32'h0000_8000);
      chk("bp_hold_last",  {31'h0, out_last}, 32'd0);
      chk("bp_hold_valid", {31'h0, out_valid}, 32'd1);
      step();
    end
    drain_one("bp", 32'hFFFF_8000, 1'b0);
    chk("bp_empty", {29'h0, fifo_count}, 32'd0);

    // Overflow: six back-to-back strobes into a 4-deep FIFO
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(32'(i), i[0]);
    chk("ovf_count", {29'h0, fifo_count}, 32'd4);
    chk("ovf_flag",  {31'h0, overflow}, 32'd1);
`ifdef COLLECTOR_DROP_COUNT_EN
    chk("ovf_drops", {24'h0, drop_count}, 32'd2);
`endif
    for (int i = 1; i <= 4; i++) drain_one("ovf_drain", 32'(i), i[0]);
    chk("ovf_empty",  {29'h0, fifo_count}, 32'd0);
    chk("ovf_sticky", {31'h0, overflow}, 32'd1);

    // Push while full on the same cycle as the high-beat pop
    clear = 1'b1; step(); clear = 1'b0;
    chk("pf_cleared_ovf", {31'h0, overflow}, 32'd0);
`ifdef COLLECTOR_DROP_COUNT_EN
    chk("pf_cleared_drops", {24'h0, drop_count}, 32'd0);
`endif
    out_ready = 1'b0;
    for (int i = 11; i <= 14; i++) push(32'(i), 1'b0);
    chk("pf_full", {29'h0, fifo_count}, 32'd4);
    out_ready = 1'b1;
    step();                              // low half of entry 11 accepted
    chk("pf_hi_beat", {31'h0, out_last}, 32'd1);
    push(32'h0000_0007, 1'b1);           // coincides with pop of entry 11
    chk("pf_count", {29'h0, fifo_count}, 32'd4);
    chk("pf_ovf",   {31'h0, overflow}, 32'd0);
    drain_one("pf12", 32'd12, 1'b0);
    drain_one("pf13", 32'd13, 1'b0);
    drain_one("pf14", 32'd14, 1'b0);
    drain_one("pf7",  32'd7,  1'b1);
    chk("pf_empty", {29'h0, fifo_count}, 32'd0);

    // clear mid-stream in the high beat, with a same-cycle push discarded
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h100 + 32'(i), 1'b1);
    chk("clr_pre_ovf", {31'h0, overflow}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("clr_pre_hi", {31'h0, out_last}, 32'd1);
    clear = 1'b1; arith_flag_in = 1'b1; arith_out_in = 32'h5555_5555;
    out_ready = 1'b0;
    step();
    clear = 1'b0; arith_flag_in = 1'b0;
    chk_zero("clr");
    push(32'hBEEF_CAFE, 1'b0);
    chk("clr_next_valid", {31'h0, out_valid}, 32'd1);
    drain_one("clr_next", 32'hBEEF_CAFE, 1'b0);

    // Asynchronous reset mid-cycle while in the high beat
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hA000_0000 + 32'(i), 1'b1);
    out_ready = 1'b1;
    step();
    chk("rst_pre_hi", {31'h0, out_last}, 32'd1);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("arst");
    rst = 1'b0;
    step();
    chk_zero("arst_hold");
    push(32'h7654_3210, 1'b1);
    drain_one("arst_next", 32'h7654_3210, 1'b1);
    chk("arst_empty", {29'h0, fifo_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
